fifo_mac_stage: RTL and testbench

Two-stage pipelined signed multiply-accumulate stage that sits directly downstream of the MMIO-fed 64-bit FIFO in the AFU. It consumes operand pairs from the FIFO output word, with a = q[7:0] and b = q[15:8] wired at AFU level, qualified by the same enable that advances the FIFO. It maintains a saturating accumulator, an accumulation count and sticky status. The AFU exposes these over MMIO reads.

---
 rtl/fifo_mac_stage.sv | 83 ++++++++
 tb/tb_fifo_mac_stage.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/fifo_mac_stage.sv
// Two-stage signed multiply-accumulate behind the AFU FIFO.
// Stage 1 registers the full-width product. Stage 2 adds it into a clamping
// accumulator, bumps a saturating count and records sticky saturation.
module fifo_mac_stage #(
  parameter int DATA_WIDTH = 8,
  parameter int ACC_WIDTH  = 24,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         en,
  input  logic                         clr,
  input  logic signed [DATA_WIDTH-1:0] a,
  input  logic signed [DATA_WIDTH-1:0] b,
  output logic signed [ACC_WIDTH-1:0]  acc,
  output logic                         acc_valid,
  output logic [CNT_WIDTH-1:0]         count,
  output logic                         sat,
  output logic                         busy
);

  localparam int PW = 2 * DATA_WIDTH;

  localparam logic [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

  logic signed [PW-1:0]        a_x, b_x, prod_r;
  logic                        prod_v;
  logic signed [ACC_WIDTH:0]   sum;
  logic [ACC_WIDTH-1:0]        acc_nxt;
  logic                        ovf;

  // Operands widened first so the product is formed at full width.
  assign a_x  = {{DATA_WIDTH{a[DATA_WIDTH-1]}}, a};
  assign b_x  = {{DATA_WIDTH{b[DATA_WIDTH-1]}}, b};
  assign busy = prod_v;

  // Stage 1: capture product; clr drops any operand presented with it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prod_r <= '0;
      prod_v <= 1'b0;
    end else if (en && !clr) begin
      prod_r <= a_x * b_x;
      prod_v <= 1'b1;
    end else begin
      prod_v <= 1'b0;
    end
  end

  // One guard bit is enough: the product fits in ACC_WIDTH, so the two top
  // bits of the sum disagree exactly when the result left the signed range.
  always_comb begin
    sum     = {acc[ACC_WIDTH-1], acc}
            + {{(ACC_WIDTH+1-PW){prod_r[PW-1]}}, prod_r};
    ovf     = sum[ACC_WIDTH] ^ sum[ACC_WIDTH-1];
    acc_nxt = sum[ACC_WIDTH-1:0];
    if (ovf) acc_nxt = sum[ACC_WIDTH] ? ACC_MIN : ACC_MAX;
  end

  // Stage 2: accumulate, count and flag; clr wipes all of it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc       <= '0;
      acc_valid <= 1'b0;
      count     <= '0;
      sat       <= 1'b0;
    end else if (clr) begin
      acc       <= '0;
      acc_valid <= 1'b0;
      count     <= '0;
      sat       <= 1'b0;
    end else if (prod_v) begin
      acc       <= acc_nxt;
      acc_valid <= 1'b1;
      if (count != '1) count <= count + 1'b1;
      if (ovf) sat <= 1'b1;
    end else begin
      acc_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fifo_mac_stage.sv
// Bench for fifo_mac_stage: a default-width instance and a CNT_WIDTH=4 one
// share stimulus; a plain-arithmetic model is checked on every negedge and
// directed sequences pin hand-computed values.
module tb_fifo_mac_stage;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en = 1'b0, clr = 1'b0;
  logic signed [7:0]  a = '0, b = '0;
  logic signed [23:0] acc, acc4;
  logic               av, av4, sat, sat4, busy, busy4;
  logic [15:0]        count;
  logic [3:0]         count4;

  int n_chk = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  fifo_mac_stage dut (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .a(a), .b(b),
    .acc(acc), .acc_valid(av), .count(count), .sat(sat), .busy(busy)
  );

  fifo_mac_stage #(.CNT_WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .a(a), .b(b),
    .acc(acc4), .acc_valid(av4), .count(count4), .sat(sat4), .busy(busy4)
  );

  task automatic chk(input string nm, input longint act, input longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
  endtask

  // Model: pending product, accumulator held as a wide integer and clamped.
  localparam longint AMAX = (64'sd1 <<< 23) - 1;
  localparam longint AMIN = -(64'sd1 <<< 23);
  longint m_acc = 0, m_prod = 0, m_cnt = 0, m_cnt4 = 0;
  bit     m_pv = 0, m_av = 0, m_sat = 0;

  always @(posedge clk or posedge rst) begin
    longint s;
    if (rst) begin
      m_acc = 0; m_cnt = 0; m_cnt4 = 0; m_pv = 0; m_av = 0; m_sat = 0;
    end else if (clr) begin
      m_acc = 0; m_cnt = 0; m_cnt4 = 0; m_pv = 0; m_av = 0; m_sat = 0;
    end else begin
      m_av = m_pv;
      if (m_pv) begin
        s = m_acc + m_prod;
        if (s > AMAX) begin s = AMAX; m_sat = 1; end
        if (s < AMIN) begin s = AMIN; m_sat = 1; end
        m_acc = s;
        if (m_cnt < 65535) m_cnt++;
        if (m_cnt4 < 15) m_cnt4++;
      end
      m_pv = en;
      m_prod = longint'(a) * longint'(b);
    end
  end

  // Compare both instances against the model every cycle.
  always @(negedge clk) begin
    chk("acc",       acc,    m_acc);
    chk("acc_valid", av,     m_av);
    chk("count",     count,  m_cnt);
    chk("sat",       sat,    m_sat);
    chk("busy",      busy,   m_pv);
    chk("acc4",      acc4,   m_acc);
    chk("count4",    count4, m_cnt4);
    chk("sat4",      sat4,   m_sat);
    chk("av4",       av4,    m_av);
  end

  // Apply inputs just after an edge, then wait for the next edge.
  task automatic cyc(input bit e, input int aa, input int bb, input bit c);
    en = e; a = 8'(aa); b = 8'(bb); clr = c;
    @(posedge clk); #1;
  endtask

  task automatic clear();
    cyc(0, 0, 0, 1);
    clr = 0;
  endtask

  initial begin
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("rst_acc", acc, 0);
    chk("rst_busy", busy, 0);
    rst = 0;

    // Reset mid-stream with en held high.
    repeat (3) cyc(1, 5, 5, 0);
    rst = 1; #1;
    chk("mid_rst_acc", acc, 0);
    chk("mid_rst_count", count, 0);
    chk("mid_rst_av", av, 0);
    chk("mid_rst_busy", busy, 0);
    @(posedge clk); #1;
    rst = 0;
    cyc(1, 5, 5, 0);
    chk("post_rst_av1", av, 0);
    chk("post_rst_busy1", busy, 1);
    cyc(1, 5, 5, 0);
    chk("post_rst_av2", av, 1);
    chk("post_rst_acc", acc, 25);
    clear();

    // Three back-to-back 3*4 products.
    cyc(1, 3, 4, 0);
    cyc(1, 3, 4, 0); chk("run_12", acc, 12); chk("run_av", av, 1);
    cyc(1, 3, 4, 0); chk("run_24", acc, 24);
    cyc(0, 0, 0, 0); chk("run_36", acc, 36); chk("run_busy", busy, 0);
    cyc(0, 0, 0, 0);
    chk("hold_36", acc, 36); chk("hold_av", av, 0);
    chk("run_cnt", count, 3); chk("run_sat", sat, 0);
    clear();

    // Signed mix.
    cyc(1, -128, 127, 0);
    cyc(1, -1, -1, 0); chk("mix_1", acc, -16256);
    cyc(0, 0, 0, 0);   chk("mix_2", acc, -16255); chk("mix_cnt", count, 2);
    clear();

    // Positive saturation and pull-back.
    repeat (512) cyc(1, -128, -128, 0);
    chk("sat_511", acc, 8372224); chk("sat_511_flag", sat, 0);
    cyc(1, -128, 127, 0);
    chk("sat_512", acc, 8388607); chk("sat_512_flag", sat, 1);
    cyc(0, 0, 0, 0);
    chk("sat_back", acc, 8372351); chk("sat_sticky", sat, 1);
    clear();
    chk("clr_sat", sat, 0);

    // clr drops both the in-flight and the concurrent product.
    cyc(1, 10, 10, 0);
    cyc(1, 2, 2, 1);
    clr = 0;
    chk("clr_acc", acc, 0); chk("clr_cnt", count, 0); chk("clr_busy", busy, 0);
    cyc(0, 0, 0, 0); chk("clr_av", av, 0); chk("clr_acc2", acc, 0);
    cyc(1, 1, 1, 0);
    cyc(0, 0, 0, 0); chk("clr_next", acc, 1); chk("clr_next_av", av, 1);
    clear();

    // Count saturation on the narrow instance; zero operand still counts.
    repeat (20) cyc(1, 1, 1, 0);
    cyc(0, 0, 0, 0);
    chk("cnt_acc", acc, 20); chk("cnt16", count, 20); chk("cnt4", count4, 15);
    cyc(1, 0, 7, 0);
    cyc(0, 0, 0, 0);
    chk("zero_av", av, 1); chk("zero_cnt", count, 21); chk("zero_acc", acc, 20);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
